// File: rtl/collatz_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : collatz_pkg
//  Description : Shared types and constants for the Collatz step-count
//                responder: FSM state encoding, default operand width
//                (tracks intN) and the all-ones saturation constant.
//  Revision    : 1.0 - initial release
// ============================================================================
package collatz_pkg;

  // Default operand / result width, matching intN of the dataflow flow.
  localparam int INTN      = 27;
  localparam int COLLATZ_W = INTN;

  // All-ones source. Sliced to the instance width by users, so any
  // width up to SAT_MAX_W is supported.
  localparam int                   SAT_MAX_W = 64;
  localparam logic [SAT_MAX_W-1:0] SAT_ONES  = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : collatz_pkg
`default_nettype wire

// File: rtl/collatz_step.sv
`default_nettype none
// ============================================================================
//  Module      : collatz_step
//  Description : Combinational single Collatz step on an (N+2)-bit value.
//                Produces the next value (n/2 or 3n+1), a terminal flag
//                (n <= 1) and an overflow flag (3n+1 does not fit in N bits).
//  Ports       : i_n     - current value, upper two bits expected zero
//                o_next  - next value, full N+2 bits (3n+1 cannot exceed)
//                o_done  - value has reached 0 or 1
//                o_ovf   - odd, non-terminal value whose 3n+1 exceeds N bits
//  Revision    : 1.0 - initial release
// ============================================================================
module collatz_step
  import collatz_pkg::*;
#(
  parameter int N = COLLATZ_W
) (
  input  logic [N+1:0] i_n,
  output logic [N+1:0] o_next,
  output logic         o_done,
  output logic         o_ovf
);

  logic [N+1:0] w_tri;
  logic         w_odd;

  localparam logic [N+1:0] C_ONE = {{(N+1){1'b0}}, 1'b1};

  assign w_odd  = i_n[0];
  // With i_n < 2^N, 3n+1 < 3*2^N + 1 which always fits in N+2 bits.
  assign w_tri  = (i_n << 1) + i_n + C_ONE;
  assign o_done = (i_n <= C_ONE);
  assign o_next = w_odd ? w_tri : (i_n >> 1);
  assign o_ovf  = w_odd & ~o_done & (|w_tri[N+1:N]);

endmodule : collatz_step
`default_nettype wire

// File: rtl/collatz_seq.sv
`default_nettype none
// ============================================================================
//  Module      : collatz_seq
//  Description : Iterative Collatz step counter behind a valid/ready
//                handshake. Accepts one operand in IDLE, performs one step
//                per clock in RUN, presents the step count in DONE.
//                Optional macro COLLATZ_OVF_EN adds the ovf output and
//                saturates the result to all-ones when 3n+1 overflows N bits;
//                without it, arithmetic wraps to N bits.
//  Ports       : clk, rst       - clock, async active-high reset
//                in_valid/in_ready/in0    - operand handshake
//                out_valid/out_ready/out0 - result handshake
//                ovf            - overflow qualifier (COLLATZ_OVF_EN only)
//  Revision    : 1.0 - initial release
// ============================================================================
module collatz_seq
  import collatz_pkg::*;
#(
  parameter int N = COLLATZ_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in0,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out0
`ifdef COLLATZ_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam logic [N-1:0] C_CNT_ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N+1:0] C_MASK    = {2'b00, SAT_ONES[N-1:0]};

  state_t       r_state;
  logic [N+1:0] r_n;
  logic [N-1:0] r_count;
  logic         r_in_ready;
  logic         r_out_valid;
  logic [N-1:0] r_out0;

  logic [N+1:0] w_next;
  logic         w_done;

`ifdef COLLATZ_OVF_EN
  logic         r_ovf;
  logic         w_ovf;
`else
  logic         w_unused_ovf;
`endif

  collatz_step #(
    .N (N)
  ) u_step (
    .i_n    (r_n),
    .o_next (w_next),
    .o_done (w_done),
`ifdef COLLATZ_OVF_EN
    .o_ovf  (w_ovf)
`else
    .o_ovf  (w_unused_ovf)
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_n         <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out0      <= '0;
`ifdef COLLATZ_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_n        <= {2'b00, in0};
            r_count    <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (w_done) begin
            r_out0      <= r_count;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
`ifdef COLLATZ_OVF_EN
          else if (w_ovf) begin
            r_out0      <= SAT_ONES[N-1:0];
            r_ovf       <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
`endif
          else begin
            // Keep n within N bits so the next 3n+1 fits the N+2 bit adder;
            // a no-op when overflow is detected above.
            r_n     <= w_next & C_MASK;
            r_count <= r_count + C_CNT_ONE;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
`ifdef COLLATZ_OVF_EN
            r_ovf       <= 1'b0;
`endif
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out0      = r_out0;
`ifdef COLLATZ_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule : collatz_seq
`default_nettype wire
